seq_div32: RTL
==============

Name: seq_div32

Overview:
- Iterative radix-2 restoring divider serving RV32M DIV/DIVU/REM/REMU; it is the inverse-operation counterpart to the pipelined multiplier.
- Sits beside the multiplier in the RV32M unit and uses the same start/finished handshake, so the M-unit controller drives both identically.
- Computes quotient and remainder together; RISC-V divide-by-zero and signed-overflow results are produced without trapping.

Parameters:
- WIDTH, 32, operand/result width; only 32 is verified.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- dividend  input  WIDTH  numerator; sampled only on a start cycle.
- divisor  input  WIDTH  denominator; sampled only on a start cycle.
- is_signed  input  1  1 = two's-complement operands (DIV/REM), 0 = unsigned.
- start  input  1  one-cycle request; latches operands.
- busy  output  1  high from the edge after start until finished deasserts.
- finished  output  1  one-cycle pulse; results are valid in this cycle.
- quotient  output  WIDTH  registered quotient; held until the next result is written.
- remainder  output  WIDTH  registered remainder; held likewise.

Behaviour:
- Reset (async, RST=1): state IDLE; busy=0; finished=0; quotient=0; remainder=0; iteration counter=0.
- States: IDLE, CALC, FIX, DONE.
- Any state, start=1 at edge E0:
  - latch the operand magnitudes (absolute value when is_signed=1 and MSB=1) and the sign flags;
  - clear the partial remainder and counter.
  - Next state: FIX if special, else CALC.
  - A start during CALC/FIX/DONE aborts the current operation with no finished pulse for it.
- Special cases are decided at E0:
  - divisor==0 → quotient=all ones, remainder=dividend (raw bits).
  - is_signed=1, dividend=0x80000000, divisor=0xFFFFFFFF → quotient=0x80000000, remainder=0.
- CALC, one iteration per edge:
  - shift {rem,quo} left by 1; trial = rem − divisor (WIDTH+1 bits);
  - if trial is non-negative, rem=trial and quo LSB=1, else quo LSB=0.
  - 32 iterations (edges E1..E32); counter reaching 31 → FIX.
- FIX, one edge:
  - quotient negated iff is_signed and the operand signs differ;
  - remainder negated iff is_signed and dividend is negative (remainder takes the dividend's sign);
  - outputs registered → DONE.
- DONE: finished=1 for exactly one cycle (decoded from state) → IDLE.
- Latency: normal finished is high in the cycle after E33 (34 cycles from the start edge); special case is high in the cycle after E1 (2 cycles).
- busy=1 in CALC, FIX and DONE.
- quotient/remainder change only on the FIX edge.
- Operand inputs are ignored while start=0.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: at E0, if |dividend| < |divisor| (unsigned magnitudes, divisor≠0), go straight to FIX with quo=0 and rem=|dividend|; sign fixup still applies; latency 2 cycles.
- Undefined: such operands take the full 34-cycle CALC path; results are identical.

Decomposition:
- Package rv32m_pkg holds:
  - div_state_t enum (IDLE, CALC, FIX, DONE);
  - DIV_ITERS=32;
  - constants DIV_ZERO_QUO ('1) and DIV_OVF_QUO (32'h8000_0000).
- One sub-module, div_step: combinational single restoring iteration taking {rem, quo, divisor} and producing {rem_next, quo_next}.

Test Plan:
- Unsigned 100/7 → quotient=14, remainder=2; finished exactly 34 cycles after start; busy high throughout.
- Signed −7/2 (0xFFFFFFF9/2) → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; signed 7/−2 → quotient=0xFFFFFFFD, remainder=1.
- Divide by zero, dividend 0x00001234 with is_signed 0 and 1 → quotient=0xFFFFFFFF, remainder=0x00001234, finished 2 cycles after start.
- Signed overflow 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0; unsigned 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0.
- Abort and reset:
  - start 50/5, then at cycle 10 start 9/4 → only one finished pulse, at cycle 10+34, with quotient=2, remainder=1.
  - RST asserted mid-CALC → all outputs 0 immediately; no finished pulse afterwards.
- Early-out, 3/10:
  - with DIV_EARLY_OUT_EN → quotient=0, remainder=3, latency 2;
  - without it → same result, latency 34.

Source files
------------

// File: rtl/rv32m_pkg.sv
// +-----------------------------------------------------------------------------
// | Module   : rv32m_pkg
// | Brief    : Shared types and constants for the RV32M divide/multiply unit.
// | Revision : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package rv32m_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

   localparam int          DIV_ITERS    = 32;
   localparam logic [31:0] DIV_ZERO_QUO = '1;
   localparam logic [31:0] DIV_OVF_QUO  = 32'h8000_0000;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// +-----------------------------------------------------------------------------
// | Module   : div_step
// | Brief    : One combinational radix-2 restoring division iteration.
// | Revision : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             fits;

   // The shifted partial remainder needs one extra bit before the trial subtract.
   assign shifted  = {rem, quo[WIDTH-1]};
   assign fits     = (shifted >= {1'b0, divisor});
   assign diff     = WIDTH'(shifted - {1'b0, divisor});
   assign rem_next = fits ? diff : shifted[WIDTH-1:0];
   assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

`default_nettype wire

// File: rtl/seq_div32.sv
// +-----------------------------------------------------------------------------
// | Module   : seq_div32
// | Brief    : Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// |            Optional macro DIV_EARLY_OUT_EN skips iterations when |a| < |b|.
// | Revision : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module seq_div32
   import rv32m_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             is_signed,
   input  logic             start,
   output logic             busy,
   output logic             finished,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = $clog2(DIV_ITERS);

   div_state_t       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem_work;
   logic [WIDTH-1:0] quo_work;
   logic [WIDTH-1:0] dvsr;
   logic             neg_quo;
   logic             neg_rem;
   logic             special;

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             div_zero;
   logic             overflow;
   logic             early;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_quo;

   assign a_neg    = is_signed & dividend[WIDTH-1];
   assign b_neg    = is_signed & divisor[WIDTH-1];
   assign a_mag    = a_neg ? -dividend : dividend;
   assign b_mag    = b_neg ? -divisor  : divisor;
   assign div_zero = (divisor == '0);
   assign overflow = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);

`ifdef DIV_EARLY_OUT_EN
   assign early = !div_zero && (a_mag < b_mag);
`else
   assign early = 1'b0;
`endif

   div_step #(
      .WIDTH    (WIDTH)
   ) u_step (
      .rem      (rem_work),
      .quo      (quo_work),
      .divisor  (dvsr),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         cnt       <= '0;
         rem_work  <= '0;
         quo_work  <= '0;
         dvsr      <= '0;
         neg_quo   <= 1'b0;
         neg_rem   <= 1'b0;
         special   <= 1'b0;
         busy      <= 1'b0;
         finished  <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else if (start) begin
         // A new request always wins, silently dropping any operation in flight.
         dvsr     <= b_mag;
         neg_quo  <= a_neg ^ b_neg;
         neg_rem  <= a_neg;
         cnt      <= '0;
         busy     <= 1'b1;
         finished <= 1'b0;
         if (div_zero) begin
            rem_work <= dividend;
            quo_work <= DIV_ZERO_QUO;
            special  <= 1'b1;
            state    <= FIX;
         end else if (overflow) begin
            rem_work <= '0;
            quo_work <= DIV_OVF_QUO;
            special  <= 1'b1;
            state    <= FIX;
         end else if (early) begin
            rem_work <= a_mag;
            quo_work <= '0;
            special  <= 1'b0;
            state    <= FIX;
         end else begin
            rem_work <= '0;
            quo_work <= a_mag;
            special  <= 1'b0;
            state    <= CALC;
         end
      end else begin
         case (state)
            IDLE: begin
               busy     <= 1'b0;
               finished <= 1'b0;
            end
            CALC: begin
               rem_work <= step_rem;
               quo_work <= step_quo;
               cnt      <= cnt + 1'b1;
               if (cnt == CW'(DIV_ITERS - 1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               // Special-case results are architecturally fixed bit patterns, never sign-adjusted.
               quotient  <= (!special && neg_quo) ? -quo_work : quo_work;
               remainder <= (!special && neg_rem) ? -rem_work : rem_work;
               finished  <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               finished <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
